// File: rtl/shift_ram_prog_if.sv
// ----------------------------------------------------------------------------
// shift_ram_prog_if
// Bundles the data/config/status signals of the programmable delay line.
//   master : drives en, si, cfg_load, cfg_delay; observes so, so_valid, fill,
//            delay_q (the upstream/control side)
//   slave  : the delay line itself
// DW_D is derived from MAX_DEPTH and must match the delay line's own value,
// so instantiate this with the same MAX_DEPTH as the shift_ram_prog.
// ----------------------------------------------------------------------------
interface shift_ram_prog_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DEPTH  = 64
);
    localparam int DW_D = $clog2(MAX_DEPTH + 1);

    logic                  en;         // shift enable
    logic [DATA_WIDTH-1:0] si;         // data in
    logic                  cfg_load;   // load cfg_delay and flush
    logic [DW_D-1:0]       cfg_delay;  // requested delay
    logic [DATA_WIDTH-1:0] so;         // delayed data out
    logic                  so_valid;   // so holds a word from exactly D enables ago
    logic [DW_D-1:0]       fill;       // valid words held, saturating at D
    logic [DW_D-1:0]       delay_q;    // delay currently in effect

    modport master (
        output en, si, cfg_load, cfg_delay,
        input  so, so_valid, fill, delay_q
    );

    modport slave (
        input  en, si, cfg_load, cfg_delay,
        output so, so_valid, fill, delay_q
    );
endinterface

// File: rtl/shift_ram_prog.sv
// ----------------------------------------------------------------------------
// shift_ram_prog
// Runtime-programmable RAM delay line. Each enabled cycle writes si into a
// circular buffer of delay_q words and reads back the word written delay_q
// enables earlier. A fill counter gates the output, so after reset or a
// reconfiguration stale RAM contents are never presented.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : shift_ram_prog_if.slave (en, si, cfg_load, cfg_delay in;
//           so, so_valid, fill, delay_q out)
// ----------------------------------------------------------------------------
module shift_ram_prog #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_DEPTH   = 64,
    parameter int RESET_DEPTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_ram_prog_if.slave       bus
);
    localparam int DW_D  = $clog2(MAX_DEPTH + 1);
    localparam int PTR_W = $clog2(MAX_DEPTH);

    localparam logic [DW_D-1:0] C_ONE       = DW_D'(1);
    localparam logic [DW_D-1:0] C_MAX_DEPTH = DW_D'(MAX_DEPTH);
    localparam logic [DW_D-1:0] C_RST_DEPTH = DW_D'(RESET_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [MAX_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [PTR_W-1:0]      r_ptr;
    logic [DW_D-1:0]       r_fill;
    logic [DW_D-1:0]       r_delay;
    logic                  r_valid;

    logic                  w_push;
    logic                  w_ptr_last;
    logic                  w_full;
    logic [DW_D-1:0]       w_delay_clamped;

    // A reconfiguration wins over a simultaneous enable; that word is dropped.
    assign w_push     = bus.en && !bus.cfg_load;
    assign w_ptr_last = (DW_D'(r_ptr) == (r_delay - C_ONE));
    assign w_full     = (r_fill == r_delay);

    assign w_delay_clamped = (bus.cfg_delay == '0)         ? C_ONE       :
                             (bus.cfg_delay > C_MAX_DEPTH) ? C_MAX_DEPTH :
                                                             bus.cfg_delay;

    // Storage: synchronous write with read-before-write on the same address,
    // and a registered read port with enable, which maps onto block RAM.
    // NOTE: the RAM has no reset; a reset would prevent block RAM mapping, and
    // stale contents are harmless because r_valid gates them from the output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_ptr] <= bus.si;
            r_rd_data    <= r_mem[r_ptr];
        end
    end

    // Control state. The old word is only meaningful once fill has reached
    // the delay before this edge, i.e. on the (D+1)th enable after a flush.
    // NOTE: non-blocking assignments throughout, so every register samples the
    // pre-edge values of the others (r_valid below uses the old r_fill).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_fill  <= '0;
            r_delay <= C_RST_DEPTH;
            r_valid <= 1'b0;
        end else if (bus.cfg_load) begin
            r_ptr   <= '0;
            r_fill  <= '0;
            r_delay <= w_delay_clamped;
            r_valid <= 1'b0;
        end else if (w_push) begin
            r_ptr   <= w_ptr_last ? '0 : r_ptr + PTR_W'(1);
            r_fill  <= w_full ? r_fill : r_fill + C_ONE;
            r_valid <= w_full;
        end
    end

    // so is the registered read word, forced to zero whenever it is not a
    // valid delayed word; both operands are flops, so no input reaches an
    // output combinationally. Holding r_rd_data and r_valid on idle cycles
    // holds so as well.
    assign bus.so       = r_valid ? r_rd_data : '0;
    assign bus.so_valid = r_valid;
    assign bus.fill     = r_fill;
    assign bus.delay_q  = r_delay;

endmodule

// File: tb/tb_shift_ram_prog.sv
// ----------------------------------------------------------------------------
// tb_shift_ram_prog
// Directed sequence with randomized data/enables, checked against a queue
// model of the delay line: every pushed word is appended, and once more than
// D words are held the oldest one pops out as the expected output.
// ----------------------------------------------------------------------------
module tb_shift_ram_prog;
    localparam int DATA_WIDTH  = 32;
    localparam int MAX_DEPTH   = 64;
    localparam int RESET_DEPTH = 24;
    localparam int DW_D        = $clog2(MAX_DEPTH + 1);

    logic clk;
    logic rst_n;

    shift_ram_prog_if #(.DATA_WIDTH(DATA_WIDTH), .MAX_DEPTH(MAX_DEPTH)) bus ();

    shift_ram_prog #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DEPTH  (MAX_DEPTH),
        .RESET_DEPTH(RESET_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DATA_WIDTH-1:0] q[$];
    int                    m_delay;
    logic [DATA_WIDTH-1:0] m_so;
    logic                  m_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".so"},       64'(bus.so),       64'(m_so));
        check({tag, ".so_valid"}, 64'(bus.so_valid), 64'(m_valid));
        check({tag, ".fill"},     64'(bus.fill),     64'(q.size()));
        check({tag, ".delay_q"},  64'(bus.delay_q),  64'(m_delay));
    endtask

    function automatic int clamp_delay(input int d);
        if (d == 0) return 1;
        if (d > MAX_DEPTH) return MAX_DEPTH;
        return d;
    endfunction

    task automatic model_reset();
        q.delete();
        m_delay = RESET_DEPTH;
        m_so    = '0;
        m_valid = 1'b0;
    endtask

    // Apply one cycle of stimulus, update the model and check all outputs
    // one time unit after the edge.
    task automatic step(input string tag, input bit e, input logic [DATA_WIDTH-1:0] s,
                        input bit ld, input int d);
        bus.en        = e;
        bus.si        = s;
        bus.cfg_load  = ld;
        bus.cfg_delay = DW_D'(d);
        @(posedge clk);
        #1;
        if (ld) begin
            m_delay = clamp_delay(d);
            q.delete();
            m_so    = '0;
            m_valid = 1'b0;
        end else if (e) begin
            q.push_back(s);
            if (q.size() > m_delay) begin
                m_so    = q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_so    = '0;
                m_valid = 1'b0;
            end
        end
        check_all(tag);
        bus.cfg_load = 1'b0;
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] first_si;
        logic [DATA_WIDTH-1:0] post_si[4];

        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.si        = '0;
        bus.cfg_load  = 1'b0;
        bus.cfg_delay = '0;
        model_reset();
        #23;
        check_all("reset");
        #4 rst_n = 1'b1;

        // Default delay 24, ramp 1,2,3,...
        for (int k = 1; k <= 30; k++) begin
            step("d24_ramp", 1'b1, DATA_WIDTH'(k), 1'b0, 0);
            if (k == 24) check("d24_not_yet_valid", 64'(bus.so_valid), 64'd0);
            if (k == 25) check("d24_first_so", 64'(bus.so), 64'd1);
            if (k == 26) check("d24_second_so", 64'(bus.so), 64'd2);
        end
        check("d24_fill_saturated", 64'(bus.fill), 64'd24);

        // Delay 5 with random enable gaps; so must hold through idle cycles.
        step("load5", 1'b0, '0, 1'b1, 5);
        for (int k = 0; k < 60; k++)
            step("d5_rand", 1'($urandom_range(0, 1)), DATA_WIDTH'(32'h100 + k), 1'b0, 0);

        // cfg_delay = 0 maps to 1.
        step("load0", 1'b1, 32'hdead_beef, 1'b1, 0);
        check("d1_clamped", 64'(bus.delay_q), 64'd1);
        first_si = $urandom;
        step("d1_first", 1'b1, first_si, 1'b0, 0);
        check("d1_first_not_valid", 64'(bus.so_valid), 64'd0);
        step("d1_second", 1'b1, $urandom, 1'b0, 0);
        check("d1_second_so", 64'(bus.so), 64'(first_si));
        for (int k = 0; k < 10; k++)
            step("d1_rand", 1'($urandom_range(0, 1)), $urandom, 1'b0, 0);

        // Above-range request clamps to MAX_DEPTH.
        step("load_over", 1'b0, '0, 1'b1, MAX_DEPTH + 3);
        check("dmax_clamped", 64'(bus.delay_q), 64'(MAX_DEPTH));
        for (int k = 1; k <= MAX_DEPTH + 4; k++) begin
            step("dmax_fill", 1'b1, $urandom, 1'b0, 0);
            if (k == MAX_DEPTH)     check("dmax_not_yet_valid", 64'(bus.so_valid), 64'd0);
            if (k == MAX_DEPTH + 1) check("dmax_first_valid", 64'(bus.so_valid), 64'd1);
        end

        // Reconfigure mid-stream with en high: that word is dropped.
        step("load8", 1'b0, '0, 1'b1, 8);
        for (int k = 0; k < 12; k++)
            step("d8_stream", 1'b1, $urandom, 1'b0, 0);
        check("d8_streaming_valid", 64'(bus.so_valid), 64'd1);
        step("reload3_with_en", 1'b1, 32'h0bad_0bad, 1'b1, 3);
        check("reload_valid_drop", 64'(bus.so_valid), 64'd0);
        check("reload_fill_zero", 64'(bus.fill), 64'd0);
        for (int k = 0; k < 4; k++) begin
            post_si[k] = $urandom;
            step("d3_post", 1'b1, post_si[k], 1'b0, 0);
        end
        check("d3_first_so", 64'(bus.so), 64'(post_si[0]));

        // Asynchronous reset between clock edges.
        for (int k = 0; k < 5; k++)
            step("d3_more", 1'b1, $urandom, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step("post_reset", 1'b1, $urandom, 1'b0, 0);
            if (k == 1) check("post_reset_fill1", 64'(bus.fill), 64'd1);
        end

        // Full-depth wrap: three passes around the buffer with a ramp.
        step("load_max", 1'b0, '0, 1'b1, MAX_DEPTH);
        for (int k = 0; k < 3 * MAX_DEPTH; k++)
            step("wrap_ramp", 1'b1, DATA_WIDTH'(32'h5000 + k), 1'b0, 0);
        check("wrap_last_so", 64'(bus.so), 64'(32'h5000 + 2 * MAX_DEPTH - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_ram_prog.md
Name: shift_ram_prog

Overview:
- Parametrised, runtime-programmable delay line; the next generation of the team's fixed-depth RAM shift register.
- Each enabled cycle pushes one word in and pops the word pushed D enables earlier. D is loadable at run time, from 1 to MAX_DEPTH.
- Adds an output-valid flag, a fill counter and a flush-on-reconfigure rule.
- Sits between NewHope NTT/sampler pipeline stages to balance stage latencies without a fixed-depth instance per path.

Parameters:
- DATA_WIDTH, 32: width of each stored word.
- MAX_DEPTH, 64: maximum programmable delay and physical storage depth (>=2).
- RESET_DEPTH, 24: delay D in effect after reset (1..MAX_DEPTH).
- DW_D = $clog2(MAX_DEPTH+1): localparam, width of the delay and fill fields.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  shift enable; one push/pop per cycle while high.
- si  in  DATA_WIDTH  data shifted in.
- cfg_load  in  1  single-cycle pulse; load cfg_delay and flush.
- cfg_delay  in  DW_D  requested delay D.
- so  out  DATA_WIDTH  delayed data (registered).
- so_valid  out  1  high when so holds a word pushed exactly D enables earlier.
- fill  out  DW_D  number of valid words held, saturating at D.
- delay_q  out  DW_D  delay D currently in effect.

Behaviour:
- Reset (rst_n low, async):
  - so=0, so_valid=0, fill=0, delay_q=RESET_DEPTH.
  - Write pointer ptr=0.
  - Storage contents are not cleared.
- Storage:
  - MAX_DEPTH x DATA_WIDTH single-clock RAM, read-before-write at the same address.
  - Mappable to dual-port block RAM.
  - Only addresses 0..delay_q-1 are used.
- Enabled cycle (en=1, cfg_load=0):
  - mem[ptr] <= si, and the old mem[ptr] is read in the same cycle.
  - ptr <= (ptr == delay_q-1) ? 0 : ptr+1.
  - fill <= min(fill+1, delay_q).
  - If fill == delay_q before the edge: so <= old mem[ptr], so_valid <= 1.
  - Otherwise: so <= 0, so_valid <= 0.
- Timing:
  - The first valid output appears on the edge of the (D+1)th enable after flush.
  - From then on, on the k-th enable, so = si from the (k-D)-th enable.
- Idle cycle (en=0, cfg_load=0): all state and outputs hold; so and so_valid are not cleared.
- cfg_load=1 (takes priority over en; a simultaneous en is dropped, and its si is not stored):
  - delay_q <= clamp(cfg_delay): 0 maps to 1, values above MAX_DEPTH map to MAX_DEPTH.
  - ptr <= 0, fill <= 0, so <= 0, so_valid <= 0.
  - This is a flush. Stale RAM data is never presented because of fill gating.
- D=1 case:
  - ptr stays 0.
  - so = si from the previous enable; valid from the 2nd enable on.
- Reset mid-operation: immediate return to reset values. The first enable after rst_n rises is treated as a post-flush enable.
- Arithmetic and widths:
  - fill and delay_q are DW_D wide, so MAX_DEPTH itself is representable.
  - ptr is $clog2(MAX_DEPTH) wide.
  - The ptr comparison uses delay_q-1, computed in DW_D bits.
- No combinational path from any input to any output.

Test Plan:
- Reset, then en=1 continuously with si=1,2,3,... and D=24: so_valid rises on the 25th enable edge with so=1; the 26th gives so=2; fill saturates at 24.
- cfg_load with cfg_delay=5, then enables with si=0x100+k and en toggled 1-0-1 randomly: every valid so equals si from exactly 5 enables earlier; so holds through en=0.
- cfg_delay=0 → delay_q=1: the 2nd enable gives so = first si. cfg_delay=MAX_DEPTH+3 → delay_q=MAX_DEPTH, with the first valid output on enable MAX_DEPTH+1.
- While streaming with D=8 and so_valid=1, pulse cfg_load (cfg_delay=3) together with en=1: so_valid drops to 0 on that edge, fill=0, that cycle's si is not stored, and the first valid so is the si from the 1st post-load enable, appearing on the 4th.
- Assert rst_n low asynchronously mid-stream, between clock edges: so=0, so_valid=0, fill=0 and delay_q=24 immediately. After release, the fill sequence restarts from the first enable.
- Wrap check with D=MAX_DEPTH over 3*MAX_DEPTH enables of a ramp: no gaps and no duplicates; so tracks si delayed by exactly MAX_DEPTH.
